ncpu32k_ifu_fq: RTL and testbench
=================================

# ncpu32k_ifu_fq

Parametrised instruction fetch unit with a decoupling fetch queue.

- Issues sequential fetch commands on the instruction bus and allows up to `FQ_DEPTH` requests in flight or buffered.
- Stores returned instructions with their PCs in a circular FIFO that feeds the IDU through a valid/ready handshake.
- On a speculative flush, redirects the PC in one cycle, empties the queue, and silently drops every stale in-flight response.
- Sits between the ibus/IMMU and `ncpu32k_idu`, and replaces the single-entry pipebuf fetch stage.

## Interface

Parameters:

- `AW`, default 32: address width; the PC is held as `AW-2` bits (word address).
- `IW`, default 32: instruction width.
- `FQ_DEPTH`, default 4: queue entries; power of two, ≥2; also the credit limit.
- `RESET_VECTOR`, default 32'h0: byte address of the first fetch.

Ports (clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low):

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `ibus_cmd_valid` out 1: fetch command present.
- `ibus_cmd_ready` in 1: ibus accepts command.
- `ibus_cmd_addr` out AW: byte address `{pc,2'b00}`.
- `ibus_dout_valid` in 1: response present.
- `ibus_dout_ready` out 1: IFU accepts response.
- `ibus_dout` in IW: instruction.
- `ibus_out_id` in AW: byte address of the instruction on `ibus_dout`.
- `specul_flush` in 1: redirect request.
- `ifu_flush_jmp_tgt` in AW-2: redirect word address.
- `idu_in_valid` out 1: head entry valid.
- `idu_in_ready` in 1: IDU accepts head.
- `idu_insn` out IW: head instruction.
- `idu_insn_pc` out AW-2: head word PC.
- `fq_count` out clog2(FQ_DEPTH)+1: entries currently buffered (debug/perf).

## Operation

- **Startup**
  - A 2-bit `start_cnt` increments after reset and saturates at 2; `started = (start_cnt==2)`.
  - No command is issued until `started`.
- **Credits**
  - `outstanding` counts commands accepted but not yet responded; `count` is FIFO occupancy.
  - `ibus_cmd_valid = started & ~specul_flush & (outstanding + count < FQ_DEPTH)`.
- **Command fire** (`ibus_cmd_valid & ibus_cmd_ready`): `pc <= pc+1`, `outstanding++`.
- **Response acceptance**
  - `ibus_dout_ready = started`; credits guarantee FIFO space, so the block never backpressures.
  - Response fire: `outstanding--`.
  - If `discard > 0`: `discard--` and the data is dropped. Otherwise push `{ibus_dout, ibus_out_id[AW-1:2]}`.
- **Pop**
  - `idu_in_valid = (count != 0) & ~specul_flush`.
  - Pop on `idu_in_valid & idu_in_ready`.
  - Push and pop in the same cycle leave `count` unchanged.
- **Flush** (`specul_flush=1`, highest priority)
  - `pc <= ifu_flush_jmp_tgt`.
  - FIFO read/write pointers and `count` go to 0.
  - `discard <= outstanding - resp_fire`; any response arriving in the flush cycle is dropped.
  - No command is issued and no push or pop occurs in the flush cycle.
  - Back-to-back flushes: each recomputes `discard` from the current `outstanding`; the last target wins.
- **Arithmetic**
  - Pointers are `clog2(FQ_DEPTH)` bits and wrap modulo `FQ_DEPTH`.
  - The PC wraps modulo 2^(AW-2).
  - `outstanding`, `discard` and `count` never exceed `FQ_DEPTH`.
- **Assertions** (under `NCPU_ENABLE_ASSERT`):
  - push when full;
  - `outstanding` underflow;
  - response with `outstanding==0`.

## Timing

- **Reset values**
  - `pc = RESET_VECTOR[AW-1:2]`; `start_cnt`, `outstanding`, `discard`, `count` and pointers = 0.
  - `ibus_cmd_valid = 0`, `ibus_dout_ready = 0`, `idu_in_valid = 0`.
  - `idu_insn` and `idu_insn_pc` = 0 (FIFO storage reset to 0).
- **First command**: `ibus_cmd_valid` rises on the 2nd rising edge after `rst_n` deasserts.
- **Latency**: a response accepted at edge N is visible as the head with `idu_in_valid=1` after edge N; 1 cycle, registered.
- **Throughput**: 1 command, 1 push and 1 pop per cycle sustained when `outstanding + count < FQ_DEPTH`.
- **Flush**
  - The command after a flush at edge N carries `ifu_flush_jmp_tgt` in cycle N+1, provided credits allow; stale responses still occupy credits until they are dropped.
- **Mid-operation reset**: `rst_n` low clears all state asynchronously. The ibus must also be reset, since in-flight responses are not tracked across reset.

## Test plan

- **Reset/start**: release reset with `ibus_cmd_ready=1` → `cmd_valid` at cycle 2, addresses 0x0, 0x4, 0x8, 0xC, then stall with `outstanding=4`.
- **Streaming**: 1-cycle response ibus, `idu_in_ready=1` → 1 instruction per cycle, `idu_insn_pc` = 0, 1, 2, … with no bubbles.
- **Backpressure**: `idu_in_ready=0` for 10 cycles → `fq_count` reaches 4, `cmd_valid=0`; release → 4 entries drained in order and fetch resumes at 0x10.
- **Flush with in-flight**: 3 outstanding, flush to 0x40 → `discard=3`, 3 responses dropped, next `idu_insn_pc=0x40`, no stale PC reaches the IDU.
- **Flush coincident with response, and back-to-back flushes** (0x40 then 0x80) → the same-cycle response is dropped and the first delivered PC is 0x80.
- **Wrap**: `AW=8`, `RESET_VECTOR=8'hF8` → PCs 0x3E, 0x3F, 0x00; pointers wrap across more than 2·`FQ_DEPTH` pushes with data intact.

Source files
------------

// File: rtl/ncpu32k_ifu_fq.sv
// ncpu32k_ifu_fq: sequential instruction fetch with a credit-limited decoupling queue
// feeding the IDU; speculative flush redirects the PC and drops stale responses.
module ncpu32k_ifu_fq #(
    parameter int AW = 32,
    parameter int IW = 32,
    parameter int FQ_DEPTH = 4,
    parameter logic [AW-1:0] RESET_VECTOR = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        ibus_cmd_valid,
    input  logic                        ibus_cmd_ready,
    output logic [AW-1:0]               ibus_cmd_addr,
    input  logic                        ibus_dout_valid,
    output logic                        ibus_dout_ready,
    input  logic [IW-1:0]               ibus_dout,
    input  logic [AW-1:0]               ibus_out_id,
    input  logic                        specul_flush,
    input  logic [AW-3:0]               ifu_flush_jmp_tgt,
    output logic                        idu_in_valid,
    input  logic                        idu_in_ready,
    output logic [IW-1:0]               idu_insn,
    output logic [AW-3:0]               idu_insn_pc,
    output logic [$clog2(FQ_DEPTH):0]   fq_count
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH = (CW+1)'(FQ_DEPTH);

    logic [1:0]    start_cnt_q, start_cnt_d;
    logic [AW-3:0] pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d, discard_q, discard_d, count_q, count_d;
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [IW-1:0] insn_q [FQ_DEPTH];
    logic [IW-1:0] insn_d [FQ_DEPTH];
    logic [AW-3:0] ipc_q [FQ_DEPTH];
    logic [AW-3:0] ipc_d [FQ_DEPTH];
    logic          started, cmd_fire, resp_fire, push, pop, unused_ok;

    always_comb begin
        started         = start_cnt_q == 2'd2;
        unused_ok       = ^ibus_out_id[1:0];
        ibus_cmd_valid  = started & ~specul_flush & (({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH);
        ibus_cmd_addr   = {pc_q, 2'b00};
        ibus_dout_ready = started;
        idu_in_valid    = (count_q != '0) & ~specul_flush;
        idu_insn        = insn_q[rptr_q];
        idu_insn_pc     = ipc_q[rptr_q];
        fq_count        = count_q;
        cmd_fire        = ibus_cmd_valid & ibus_cmd_ready;
        resp_fire       = ibus_dout_valid & ibus_dout_ready;
        push            = resp_fire & (discard_q == '0) & ~specul_flush;
        pop             = idu_in_valid & idu_in_ready;
        start_cnt_d     = started ? start_cnt_q : start_cnt_q + 2'd1;
        outstanding_d   = outstanding_q + CW'(cmd_fire) - CW'(resp_fire);
        insn_d          = insn_q;
        ipc_d           = ipc_q;
        if (push) begin
            insn_d[wptr_q] = ibus_dout;
            ipc_d[wptr_q]  = ibus_out_id[AW-1:2];
        end
        // Flush wins: whatever is still in flight at this point is stale and gets dropped.
        if (specul_flush) begin
            pc_d      = ifu_flush_jmp_tgt;
            rptr_d    = '0;
            wptr_d    = '0;
            count_d   = '0;
            discard_d = outstanding_q - CW'(resp_fire);
        end else begin
            pc_d      = pc_q + (AW-2)'(cmd_fire);
            rptr_d    = rptr_q + PW'(pop);
            wptr_d    = wptr_q + PW'(push);
            count_d   = count_q + CW'(push) - CW'(pop);
            discard_d = discard_q - CW'(resp_fire & (discard_q != '0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_cnt_q   <= '0;
            pc_q          <= RESET_VECTOR[AW-1:2];
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rptr_q        <= '0;
            wptr_q        <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                insn_q[i] <= '0;
                ipc_q[i]  <= '0;
            end
        end else begin
            start_cnt_q   <= start_cnt_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rptr_q        <= rptr_d;
            wptr_q        <= wptr_d;
            insn_q        <= insn_d;
            ipc_q         <= ipc_d;
        end
    end

`ifdef NCPU_ENABLE_ASSERT
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && count_q == CW'(FQ_DEPTH)));
            assert (!(resp_fire && outstanding_q == '0));
            assert (!(!cmd_fire && resp_fire && outstanding_q == '0));
        end
    end
`endif
endmodule

// File: tb/tb_ncpu32k_ifu_fq.sv
// tb_ncpu32k_ifu_fq: randomized scoreboard bench; ibus model tags each fetch with a
// flush epoch, so only responses from the current epoch are expected at the IDU.
module tb_ncpu32k_ifu_fq;
    localparam int AW = 16;
    localparam int IW = 32;

    typedef struct { logic [AW-1:0] addr; logic [AW-3:0] pc; int ep; } req_t;
    typedef struct { logic [IW-1:0] insn; logic [AW-3:0] pc; } exp_t;

    logic clk = 0, rst_n = 0;
    logic ibus_cmd_valid, ibus_cmd_ready, ibus_dout_valid, ibus_dout_ready;
    logic [AW-1:0] ibus_cmd_addr, ibus_out_id;
    logic [IW-1:0] ibus_dout, idu_insn;
    logic specul_flush, idu_in_valid, idu_in_ready;
    logic [AW-3:0] ifu_flush_jmp_tgt, idu_insn_pc;
    logic [2:0] fq_count;

    req_t pend[$];
    exp_t sb[$];
    exp_t me;
    req_t r;
    logic [AW-3:0] mpc = 14'h3FFE;
    int epoch = 0, edges = 0, n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    ncpu32k_ifu_fq #(.AW(AW), .IW(IW), .FQ_DEPTH(4), .RESET_VECTOR(16'hFFF8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_ready(ibus_cmd_ready), .ibus_cmd_addr(ibus_cmd_addr),
        .ibus_dout_valid(ibus_dout_valid), .ibus_dout_ready(ibus_dout_ready), .ibus_dout(ibus_dout),
        .ibus_out_id(ibus_out_id), .specul_flush(specul_flush), .ifu_flush_jmp_tgt(ifu_flush_jmp_tgt),
        .idu_in_valid(idu_in_valid), .idu_in_ready(idu_in_ready), .idu_insn(idu_insn),
        .idu_insn_pc(idu_insn_pc), .fq_count(fq_count)
    );

    function automatic logic [IW-1:0] data_of(logic [AW-1:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares every cycle against the model before the edge commits.
    always @(negedge clk) begin
        automatic bit st = edges >= 2;
        automatic int occ = sb.size();
        chk("dout_ready", ibus_dout_ready, st);
        chk("cmd_valid", ibus_cmd_valid, st && !specul_flush && (pend.size() + occ < 4));
        if (ibus_cmd_valid && ibus_cmd_ready) chk("cmd_addr", ibus_cmd_addr, {mpc, 2'b00});
        chk("fq_count", fq_count, occ);
        chk("idu_valid", idu_in_valid, occ != 0 && !specul_flush);
        if (idu_in_valid && idu_in_ready && occ != 0) begin
            me = sb.pop_front();
            chk("idu_insn", idu_insn, me.insn);
            chk("idu_pc", idu_insn_pc, me.pc);
        end
    end

    // Advance the model by the transfers that commit at the coming edge.
    task automatic step();
        bit cf, rf, fl;
        @(negedge clk);
        #1;
        cf = ibus_cmd_valid & ibus_cmd_ready;
        rf = ibus_dout_valid & ibus_dout_ready;
        fl = specul_flush;
        if (rf && pend.size() != 0) begin
            r = pend.pop_front();
            if (!fl && r.ep == epoch) sb.push_back('{insn: data_of({r.pc, 2'b00}), pc: r.pc});
        end
        if (cf) begin
            pend.push_back('{addr: ibus_cmd_addr, pc: mpc, ep: epoch});
            mpc = mpc + 1'b1;
        end
        if (fl) begin
            epoch++;
            sb.delete();
            mpc = ifu_flush_jmp_tgt;
        end
        @(posedge clk);
        if (rst_n) edges++;
        #1;
    endtask

    task automatic drive(bit cr, bit rv, bit ir, bit fl, logic [AW-3:0] tgt);
        ibus_cmd_ready    = cr;
        idu_in_ready      = ir;
        specul_flush      = fl;
        ifu_flush_jmp_tgt = tgt;
        ibus_dout_valid   = rv && pend.size() != 0;
        ibus_out_id       = pend.size() != 0 ? pend[0].addr : '0;
        ibus_dout         = data_of(ibus_out_id);
    endtask

    task automatic run(int n, bit cr, bit rv, bit ir);
        repeat (n) begin
            drive(cr, rv, ir, 0, '0);
            step();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (pend.size() != 0 || sb.size() != 0); i++) begin
            drive(0, 1, 1, 0, '0);
            step();
        end
        chk("drain_fq", fq_count, 0);
    endtask

    task automatic first_pc(string nm, logic [AW-3:0] want);
        for (int i = 0; i < 20 && !idu_in_valid; i++) begin
            drive(1, 1, 0, 0, '0);
            step();
        end
        chk(nm, idu_insn_pc, want);
    endtask

    initial begin
        drive(0, 0, 0, 0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_valid", ibus_cmd_valid, 0);
        chk("rst_cmd_addr", ibus_cmd_addr, 16'hFFF8);
        chk("rst_idu_valid", idu_in_valid, 0);
        chk("rst_insn", idu_insn, 0);
        chk("rst_insn_pc", idu_insn_pc, 0);
        chk("rst_fq_count", fq_count, 0);
        rst_n = 1;
        run(8, 1, 0, 1);
        chk("start_outstanding", pend.size(), 4);
        chk("start_stall", ibus_cmd_valid, 0);
        run(20, 1, 1, 1);
        run(10, 1, 1, 0);
        chk("bp_fq_count", fq_count, 4);
        chk("bp_cmd_valid", ibus_cmd_valid, 0);
        run(10, 1, 1, 1);
        drain();
        run(3, 1, 0, 1);
        chk("flush_inflight", pend.size(), 3);
        drive(1, 0, 1, 1, 14'h40);
        step();
        first_pc("flush_first_pc", 14'h40);
        run(15, 1, 1, 1);
        drain();
        run(2, 1, 0, 1);
        drive(1, 1, 1, 1, 14'h40);
        step();
        drive(1, 1, 1, 1, 14'h80);
        step();
        first_pc("b2b_first_pc", 14'h80);
        run(15, 1, 1, 1);
        repeat (3000) begin
            drive($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 4 != 0,
                  $urandom % 20 == 0, AW'($urandom) >> 2);
            step();
        end
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
